// File: rtl/wb_pkg.sv
// wb_pkg: shared state encoding, sizing helper and default SoC address map for the Wishbone fabric
package wb_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, ERRRESP} state_t;

    localparam logic [31:0] BOOTROM_BASE = 32'hb000_0000;
    localparam logic [31:0] SRAM_BASE    = 32'hb000_8000;
    localparam logic [31:0] IO_BASE      = 32'hc000_0000;
    localparam logic [31:0] BOOTROM_MASK = 32'hffff_8000;
    localparam logic [31:0] SRAM_MASK    = 32'hffff_8000;
    localparam logic [31:0] IO_MASK      = 32'hfff0_0000;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: combinational base/mask decode to one-hot hit, slave index and unmapped flag
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int N_SLAVES = 2,
    parameter int AW = 32,
    parameter int IW = (N_SLAVES > 1) ? clog2(N_SLAVES) : 1,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = {SRAM_BASE, BOOTROM_BASE},
    parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = {SRAM_MASK, BOOTROM_MASK}
) (
    input  logic [AW-1:0]       addr,
    output logic [N_SLAVES-1:0] hit,
    output logic [IW-1:0]       idx,
    output logic                unmapped
);

    // scanning downwards lets the lowest matching slave overwrite the others
    always_comb begin
        idx = '0;
        unmapped = 1'b1;
        hit = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--)
            if ((addr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                idx = IW'(k);
                unmapped = 1'b0;
            end
        for (int k = 0; k < N_SLAVES; k++)
            hit[k] = !unmapped && idx == IW'(k);
    end

endmodule

// File: rtl/wb_interconnect.sv
// wb_interconnect: single-master to N-slave pipelined Wishbone B4 fabric with outstanding tracking and bus errors
module wb_interconnect
    import wb_pkg::*;
#(
    parameter int N_SLAVES = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = {SRAM_BASE, BOOTROM_BASE},
    parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = {SRAM_MASK, BOOTROM_MASK},
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wb_cyc,
    input  logic                   i_wb_stb,
    input  logic                   i_wb_we,
    input  logic [AW-1:0]          i_wb_addr,
    input  logic [DW-1:0]          i_wb_data,
    input  logic [DW/8-1:0]        i_wb_sel,
    output logic [DW-1:0]          o_wb_data,
    output logic                   o_wb_stall,
    output logic                   o_wb_ack,
    output logic                   o_wb_err,
    output logic [AW-1:0]          o_fault_addr,
    output logic [N_SLAVES-1:0]    o_s_cyc,
    output logic [N_SLAVES-1:0]    o_s_stb,
    output logic                   o_s_we,
    output logic [AW-1:0]          o_s_addr,
    output logic [DW-1:0]          o_s_data,
    output logic [DW/8-1:0]        o_s_sel,
    input  logic [N_SLAVES*DW-1:0] i_s_data,
    input  logic [N_SLAVES-1:0]    i_s_stall,
    input  logic [N_SLAVES-1:0]    i_s_ack,
    input  logic [N_SLAVES-1:0]    i_s_err
);

    localparam int IW = (N_SLAVES > 1) ? clog2(N_SLAVES) : 1;
    localparam int CW = clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

    state_t state;
    logic [IW-1:0] cur_sel, idx;
    logic [CW-1:0] count, cnt_nxt;
    logic [TW-1:0] tmo;
    logic [N_SLAVES-1:0] hit;
    logic unmapped, busy, req, err_pend, own_stall, accept, s_ack, s_err, resp, tmo_hit;

    wb_addr_decode #(
        .N_SLAVES(N_SLAVES), .AW(AW), .IW(IW), .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
    ) u_decode (
        .addr(i_wb_addr), .hit(hit), .idx(idx), .unmapped(unmapped)
    );

    assign o_s_we = i_wb_we;
    assign o_s_addr = i_wb_addr;
    assign o_s_data = i_wb_data;
    assign o_s_sel = i_wb_sel;

    always_comb begin
        busy = count != '0;
        req = i_wb_cyc && i_wb_stb;
        err_pend = state == ERRRESP;
        // a new target is only reachable once every response from the current slave is back
        own_stall = (count == CW'(MAX_OUTSTANDING)) || (busy && (unmapped || idx != cur_sel)) || err_pend;
        o_wb_stall = own_stall || (!unmapped && i_s_stall[idx]);
        accept = req && !o_wb_stall;
        s_ack = busy && i_s_ack[cur_sel];
        s_err = busy && i_s_err[cur_sel];
        resp = s_ack || s_err;
        tmo_hit = TIMEOUT != 0 && busy && !resp && tmo == TW'(TIMEOUT);
        o_wb_ack = s_ack;
        o_wb_err = s_err || tmo_hit || err_pend;
        o_wb_data = i_s_data[cur_sel*DW +: DW];
        o_s_stb = hit & {N_SLAVES{req && !own_stall}};
        o_s_cyc = {N_SLAVES{i_wb_cyc}} & (o_s_stb | ({N_SLAVES{busy}} & (N_SLAVES'(1) << cur_sel)));
        cnt_nxt = count + CW'(accept) - CW'(resp);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cur_sel <= '0;
            count <= '0;
            tmo <= '0;
            o_fault_addr <= '0;
        end else if (!i_wb_cyc) begin
            state <= IDLE;
            count <= '0;
            tmo <= '0;
        end else begin
            count <= tmo_hit ? '0 : cnt_nxt;
            tmo <= (TIMEOUT == 0 || tmo_hit || !busy || resp) ? '0 : tmo + 1'b1;
            state <= (accept && unmapped) ? ERRRESP : (!tmo_hit && cnt_nxt != '0) ? ACTIVE : IDLE;
            if (accept && !unmapped)
                cur_sel <= idx;
            if (accept && unmapped)
                o_fault_addr <= i_wb_addr;
        end
    end

endmodule

// File: tb/tb_wb_interconnect.sv
// tb_wb_interconnect: directed stimulus with a queue-level bus model checked every cycle plus literal spot checks
module tb_wb_interconnect;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0] sel = 4'hf;
    logic [31:0] rdata, fault;
    logic stall, ack, err;
    logic [1:0] s_cyc, s_stb;
    logic [1:0] s_stall = '0, s_ack = '0, s_err = '0;
    logic s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_sel;
    logic [63:0] s_rdata = '0;

    int errors = 0;
    int checks = 0;

    wb_interconnect #(
        .N_SLAVES(2), .AW(32), .DW(32), .MAX_OUTSTANDING(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_data(rdata), .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_fault_addr(fault),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_data(s_wdata), .o_s_sel(s_sel),
        .i_s_data(s_rdata), .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_err(s_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: number of outstanding requests, slave they belong to, pending error and idle-wait length
    logic [31:0] base [2] = '{32'hb000_0000, 32'hb000_8000};
    logic [31:0] mask [2] = '{32'hffff_8000, 32'hffff_8000};
    int m_q = 0, m_sel = 0, m_silent = 0, m_tgt;
    bit m_errp = 0, m_acc, m_ack, m_err, m_tmo, m_block, m_stall;
    logic [31:0] m_fault = '0;
    logic [1:0] m_stb, m_cyc;

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < 2; k++)
            if ((a & mask[k]) == base[k])
                return k;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            m_q = 0; m_sel = 0; m_silent = 0; m_errp = 0; m_fault = '0;
        end
        m_tgt = decode(addr);
        m_block = m_q == 4 || (m_q > 0 && m_tgt != m_sel) || m_errp;
        m_stall = m_block || (m_tgt >= 0 && s_stall[m_tgt] == 1'b1);
        m_ack = m_q > 0 && s_ack[m_sel] == 1'b1;
        m_err = m_q > 0 && s_err[m_sel] == 1'b1;
        m_tmo = m_q > 0 && !m_ack && !m_err && m_silent == 8;
        m_stb = (cyc && stb && !m_block && m_tgt >= 0) ? 2'(1 << m_tgt) : 2'b00;
        m_cyc = cyc ? (m_stb | (m_q > 0 ? 2'(1 << m_sel) : 2'b00)) : 2'b00;
        chk("model_ack", {31'd0, ack}, {31'd0, m_ack});
        chk("model_err", {31'd0, err}, {31'd0, m_err || m_tmo || m_errp});
        chk("model_s_stb", {30'd0, s_stb}, {30'd0, m_stb});
        chk("model_s_cyc", {30'd0, s_cyc}, {30'd0, m_cyc});
        chk("model_fault", fault, m_fault);
        if (cyc && stb)
            chk("model_stall", {31'd0, stall}, {31'd0, m_stall});
        if (m_ack)
            chk("model_data", rdata, s_rdata[m_sel*32 +: 32]);
        if (reset) begin
            if (!cyc) begin
                m_q = 0; m_silent = 0; m_errp = 0;
            end else begin
                m_acc = stb && !m_stall;
                m_silent = (m_tmo || m_q == 0 || m_ack || m_err) ? 0 : m_silent + 1;
                m_q = m_tmo ? 0 : m_q + int'(m_acc) - int'(m_ack || m_err);
                m_errp = m_acc && m_tgt < 0;
                if (m_acc && m_tgt < 0) m_fault = addr;
                if (m_acc && m_tgt >= 0) m_sel = m_tgt;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        cyc = 0; stb = 0; we = 0; s_ack = '0; s_err = '0; s_stall = '0;
        step();
    endtask

    task automatic rq(input logic [31:0] a);
        cyc = 1; stb = 1; addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        @(negedge clk);
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_s_cyc", {30'd0, s_cyc}, 32'd0);
        chk("reset_fault", fault, 32'd0);
        step();
        reset = 1;
        step();

        // single read from bootrom
        rq(32'hb000_0004);
        @(negedge clk);
        chk("t1_stb", {30'd0, s_stb}, 32'd1);
        chk("t1_stall", {31'd0, stall}, 32'd0);
        step();
        stb = 0; s_ack = 2'b01; s_rdata[31:0] = 32'hdeadbeef;
        @(negedge clk);
        chk("t1_ack", {31'd0, ack}, 32'd1);
        chk("t1_data", rdata, 32'hdeadbeef);
        step();
        s_ack = '0;
        @(negedge clk);
        chk("t1_ack_low", {31'd0, ack}, 32'd0);
        step();
        gap();

        // three pipelined reads to sram, acks three cycles after each request
        for (int i = 0; i < 6; i++) begin
            cyc = 1; stb = i < 3; addr = 32'hb000_8000 + 32'(4 * i);
            s_ack = (i >= 3) ? 2'b10 : 2'b00;
            s_rdata[63:32] = 32'h100 + 32'(i);
            @(negedge clk);
            if (i < 3) chk("t2_stall", {31'd0, stall}, 32'd0);
            else begin
                chk("t2_ack", {31'd0, ack}, 32'd1);
                chk("t2_data", rdata, 32'h100 + 32'(i));
            end
            step();
        end
        gap();

        // switching slaves waits for the bootrom response
        rq(32'hb000_0000);
        step();
        addr = 32'hb000_8000;
        @(negedge clk);
        chk("t3_stall", {31'd0, stall}, 32'd1);
        chk("t3_stb", {30'd0, s_stb}, 32'd0);
        step();
        s_ack = 2'b01;
        @(negedge clk);
        chk("t3_stall_ack", {31'd0, stall}, 32'd1);
        chk("t3_ack0", {31'd0, ack}, 32'd1);
        step();
        s_ack = '0;
        @(negedge clk);
        chk("t3_go", {31'd0, stall}, 32'd0);
        chk("t3_stb1", {30'd0, s_stb}, 32'd2);
        step();
        stb = 0; s_ack = 2'b10;
        @(negedge clk);
        chk("t3_ack1", {31'd0, ack}, 32'd1);
        step();
        gap();

        // unmapped access
        rq(32'hc000_1234);
        @(negedge clk);
        chk("t4_stb", {30'd0, s_stb}, 32'd0);
        step();
        stb = 0;
        @(negedge clk);
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_fault", fault, 32'hc000_1234);
        step();
        @(negedge clk);
        chk("t4_err_low", {31'd0, err}, 32'd0);
        step();
        gap();

        // timeout: error on cycle 9 after accept
        rq(32'hb000_0000);
        step();
        stb = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("t5_err", {31'd0, err}, (c == 9) ? 32'd1 : 32'd0);
            step();
        end
        @(negedge clk);
        chk("t5_cyc_drop", {30'd0, s_cyc}, 32'd0);
        step();
        rq(32'hb000_0008);
        @(negedge clk);
        chk("t5_next", {30'd0, s_stb}, 32'd1);
        chk("t5_next_stall", {31'd0, stall}, 32'd0);
        step();
        stb = 0; s_ack = 2'b01;
        @(negedge clk);
        chk("t5_next_ack", {31'd0, ack}, 32'd1);
        step();
        gap();

        // master abandons cycle with two outstanding, late ack is swallowed
        rq(32'hb000_8000);
        step();
        addr = 32'hb000_8004;
        step();
        cyc = 0; stb = 0;
        @(negedge clk);
        chk("t6_cyc_drop", {30'd0, s_cyc}, 32'd0);
        step();
        s_ack = 2'b10;
        @(negedge clk);
        chk("t6_late_ack", {31'd0, ack}, 32'd0);
        step();
        cyc = 1;
        @(negedge clk);
        chk("t6_count0", {31'd0, ack}, 32'd0);
        chk("t6_s_cyc", {30'd0, s_cyc}, 32'd0);
        step();
        gap();

        // outstanding limit
        for (int i = 0; i < 5; i++) begin
            rq(32'hb000_8000 + 32'(4 * i));
            @(negedge clk);
            chk("t7_stall", {31'd0, stall}, (i == 4) ? 32'd1 : 32'd0);
            step();
        end
        stb = 0; s_ack = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t7_ack", {31'd0, ack}, 32'd1);
            step();
        end
        s_ack = '0;
        @(negedge clk);
        chk("t7_drained", {31'd0, ack}, 32'd0);
        step();
        gap();

        // slave stall, broadcast write fields, slave error
        rq(32'hb000_0010); we = 1; wdata = 32'hcafef00d; sel = 4'h3; s_stall = 2'b01;
        @(negedge clk);
        chk("t8_stall", {31'd0, stall}, 32'd1);
        chk("t8_stb", {30'd0, s_stb}, 32'd1);
        chk("t8_we", {31'd0, s_we}, 32'd1);
        chk("t8_addr", s_addr, 32'hb000_0010);
        chk("t8_wdata", s_wdata, 32'hcafef00d);
        chk("t8_sel", {28'd0, s_sel}, 32'h3);
        step();
        s_stall = '0;
        @(negedge clk);
        chk("t8_go", {31'd0, stall}, 32'd0);
        step();
        stb = 0; s_err = 2'b01;
        @(negedge clk);
        chk("t8_err", {31'd0, err}, 32'd1);
        chk("t8_no_ack", {31'd0, ack}, 32'd0);
        step();
        gap();
        sel = 4'hf;

        // asynchronous reset mid-transaction
        rq(32'hb000_0000);
        step();
        stb = 0; s_ack = 2'b01; reset = 0;
        @(negedge clk);
        chk("t9_ack", {31'd0, ack}, 32'd0);
        chk("t9_s_cyc", {30'd0, s_cyc}, 32'd0);
        chk("t9_fault", fault, 32'd0);
        step();
        reset = 1; s_ack = '0;
        step();
        gap();
        gap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
